// File: rtl/sa_instr_sequencer.sv
// Program sequencer: fetches opcodes from a small instruction memory and hands
// them to an execution unit with valid/ready/done handshaking, repeating the program.
module sa_instr_sequencer #(
    parameter int DEPTH = 8,
    parameter int IW    = 4,
    parameter int RW    = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addrI,
    input  logic [IW-1:0] dataI,
    input  logic          enI,
    input  logic [RW-1:0] cfg_repeat,
    input  logic          ap_start,
    output logic          ap_idle,
    output logic          ap_done,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [IW-1:0] op_code,
    output logic [AW-1:0] op_index,
    input  logic          op_done,
    output logic [IW-1:0] currInstruction,
    output logic [RW-1:0] pass_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_pc;
    logic [RW-1:0] r_pass;
    logic [RW-1:0] r_repeat;
    logic [IW-1:0] r_instr;
    logic          w_lastPc;
    logic          w_lastPass;
    logic          w_halt;

    assign w_lastPc   = (r_pc == AW'(DEPTH - 1));
    assign w_lastPass = (r_pass == r_repeat);
    assign w_halt     = (r_instr == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (ap_start) w_next = S_FETCH;
            S_FETCH: w_next = S_ISSUE;
            S_ISSUE: begin
                if (w_halt) begin
                    w_next = S_DONE;
                end else if (op_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (op_done) begin
                    w_next = (w_lastPc && w_lastPass) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Memory has no reset so a program survives an aborted run.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && enI) begin
            r_mem[addrI] <= dataI;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc     <= '0;
            r_pass   <= '0;
            r_repeat <= '0;
            r_instr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_repeat <= cfg_repeat;
                        r_pc     <= '0;
                        r_pass   <= '0;
                    end
                end
                S_FETCH: r_instr <= r_mem[r_pc];
                S_WAIT: begin
                    if (op_done) begin
                        if (!w_lastPc) begin
                            r_pc <= r_pc + AW'(1);
                        end else if (!w_lastPass) begin
                            r_pc   <= '0;
                            r_pass <= r_pass + RW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ap_idle         = (r_state == S_IDLE);
    assign ap_done         = (r_state == S_DONE);
    assign op_valid        = (r_state == S_ISSUE) && !w_halt;
    assign op_code         = r_instr;
    assign op_index        = r_pc;
    assign currInstruction = r_instr;
    assign pass_cnt        = r_pass;

endmodule

// File: doc/sa_instr_sequencer.md
SA_INSTR_SEQUENCER -- requirements
Module: sa_instr_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: instruction memory entries; power of two, 2..256.
REQ-002 SHALL have parameter IW, default 4: instruction/opcode width, 2..16.
REQ-003 SHALL have parameter RW, default 8: repeat-count width.
REQ-004 SHALL derive AW = clog2(DEPTH) internally.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset; synchronous, active-low.
REQ-007 SHALL have port addrI, input, AW: instruction write address.
REQ-008 SHALL have port dataI, input, IW: instruction write data.
REQ-009 SHALL have port enI, input, 1: instruction write enable.
REQ-010 SHALL have port cfg_repeat, input, RW: extra program passes (total passes = cfg_repeat+1).
REQ-011 SHALL have port ap_start, input, 1: run request.
REQ-012 SHALL have port ap_idle, output, 1: sequencer in IDLE.
REQ-013 SHALL have port ap_done, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port op_valid, output, 1: opcode offered to execution unit.
REQ-015 SHALL have port op_ready, input, 1: execution unit accepts opcode.
REQ-016 SHALL have port op_code, output, IW: current opcode.
REQ-017 SHALL have port op_index, output, AW: program counter of op_code.
REQ-018 SHALL have port op_done, input, 1: execution unit finished accepted opcode.
REQ-019 SHALL have port currInstruction, output, IW: last fetched instruction, for debug.
REQ-020 SHALL have port pass_cnt, output, RW: current pass number, 0-based.

Function
REQ-021 States SHALL be IDLE, FETCH, ISSUE, WAIT, DONE.
REQ-022 Memory SHALL be DEPTH x IW with synchronous read; read data valid one cycle after FETCH.
REQ-023 enI=1 in IDLE SHALL write dataI to mem[addrI] at the clock edge; enI in any other state SHALL be ignored.
REQ-024 IDLE: ap_idle=1; ap_start=1 SHALL latch cfg_repeat, clear pc and pass_cnt, and go to FETCH.
REQ-025 ap_start outside IDLE SHALL be ignored.
REQ-026 FETCH: one cycle reading mem[pc], then ISSUE.
REQ-027 ISSUE with fetched opcode 0 (HALT) SHALL go to DONE without asserting op_valid.
REQ-028 ISSUE with nonzero opcode SHALL assert op_valid with op_code/op_index stable until op_valid&&op_ready, then go to WAIT.
REQ-029 WAIT: op_valid=0; op_done=1 SHALL advance; op_done outside WAIT SHALL be ignored.
REQ-030 Advance with pc<DEPTH-1: pc+1, go to FETCH.
REQ-031 Advance with pc=DEPTH-1 and pass_cnt<latched repeat: pc=0, pass_cnt+1, go to FETCH.
REQ-032 Advance with pc=DEPTH-1 and pass_cnt=latched repeat: go to DONE.
REQ-033 HALT SHALL end the whole run; remaining passes SHALL NOT execute.
REQ-034 DONE: ap_done=1 for exactly one cycle, then go to IDLE.
REQ-035 pc SHALL never wrap silently; wrap occurs only via REQ-031.

Reset
REQ-036 rst=0 at a clock edge SHALL force IDLE, pc=0, pass_cnt=0, op_valid=0, ap_done=0, ap_idle=1, currInstruction=0, op_code=0, op_index=0, regardless of state.
REQ-037 Reset SHALL NOT clear instruction memory.
REQ-038 rst=0 mid-run SHALL abort without ap_done; the next run SHALL start from pc=0.

Verification
REQ-039 DEPTH=8; mem=[5,4,1,2,3,0,0,0]; cfg_repeat=0; op_ready=1; op_done one cycle after accept -> op_code 5,4,1,2,3 at op_index 0..4; ap_done in cycle 18 after ap_start sampled.
REQ-040 mem=[1..8], no HALT, cfg_repeat=1 -> 16 issues, op_index 0..7 twice, pass_cnt 0 then 1, single ap_done.
REQ-041 op_ready held low 3 cycles in ISSUE -> op_valid=1 and op_code/op_index unchanged for those cycles; exactly one WAIT entry.
REQ-042 enI=1 writing mem[0]=7 and ap_start=1 during a run -> memory unchanged, run unaffected; after ap_done, the write in IDLE takes effect on the next run.
REQ-043 rst=0 one cycle while in WAIT -> no ap_done; next cycle ap_idle=1, op_valid=0, pc=0, pass_cnt=0.
REQ-044 mem[0]=0 -> ap_done 3 cycles after ap_start sampled, op_valid never asserted.
